// File: rtl/kl_router_1by2_pkg.sv
// Shared KLink definitions for the 1-to-2 address router: size encodings,
// burst-tracker state and the beats-from-size helper.
package kl_router_1by2_pkg;

    localparam logic [2:0] KL_SIZE_8B   = 3'd3;
    localparam logic [2:0] KL_SIZE_16B  = 3'd4;
    localparam logic [2:0] KL_SIZE_32B  = 3'd5;
    localparam logic [2:0] KL_SIZE_64B  = 3'd6;
    localparam logic [2:0] KL_SIZE_128B = 3'd7;

    localparam int unsigned KL_BEATS_W = 5;
    typedef logic [KL_BEATS_W-1:0] kl_beats_t;

    localparam logic SEL_DN0 = 1'b0;
    localparam logic SEL_DN1 = 1'b1;

    typedef enum logic {
        TRK_IDLE  = 1'b0,
        TRK_BURST = 1'b1
    } trk_state_e;

    // Anything up to 8 bytes fits in one 64-bit beat.
    function automatic kl_beats_t kl_beats(input logic [2:0] size);
        kl_beats_t b;
        case (size)
            KL_SIZE_16B:  b = 5'd2;
            KL_SIZE_32B:  b = 5'd4;
            KL_SIZE_64B:  b = 5'd8;
            KL_SIZE_128B: b = 5'd16;
            default:      b = 5'd1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/kl_burst_tracker.sv
// Burst lock: remembers which downlink a multi-beat transfer started on and
// counts the remaining beats until the lock can be released.
module kl_burst_tracker
    import kl_router_1by2_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter logic        SEL_RST = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      fire,
    input  logic      start_multi,
    input  kl_beats_t beats,
    input  logic      sel_in,
    output logic      locked,
    output logic      sel_locked
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    trk_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             sel_r, sel_s;

    // Next-state: counter holds remaining beats minus one after the first beat.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sel_s   = sel_r;
        case (state_r)
            TRK_IDLE: begin
                if (fire && start_multi) begin
                    state_s = TRK_BURST;
                    cnt_s   = CNT_W'(beats - 5'd2);
                    sel_s   = sel_in;
                end else begin
                    state_s = TRK_IDLE;
                end
            end
            TRK_BURST: begin
                if (fire) begin
                    if (cnt_r == CNT_ZERO) begin
                        state_s = TRK_IDLE;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    state_s = TRK_BURST;
                end
            end
            default: begin
                state_s = TRK_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and lock registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TRK_IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= SEL_RST;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sel_r   <= sel_s;
        end
    end

    assign locked     = (state_r == TRK_BURST);
    assign sel_locked = sel_r;

endmodule

// File: rtl/kl_router_1by2.sv
// KLink 1-uplink / 2-downlink router: address-decoded request fan-out with
// write-burst locking, alternating-priority response merge with burst locking.
module kl_router_1by2
    import kl_router_1by2_pkg::*;
#(
    parameter logic [31:0] DN1_ADDR_MASK   = 32'hF000_0000,
    parameter logic [31:0] DN1_ADDR_MATCH  = 32'h8000_0000,
    parameter int unsigned MAX_BURST_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] up_req_addr,
    input  logic        up_req_wen,
    input  logic [63:0] up_req_wdata,
    input  logic [7:0]  up_req_wmask,
    input  logic [2:0]  up_req_size,
    input  logic [4:0]  up_req_srcid,
    input  logic        up_req_valid,
    output logic        up_req_ready,
    output logic [63:0] up_resp_rdata,
    output logic [2:0]  up_resp_size,
    output logic [4:0]  up_resp_dstid,
    output logic        up_resp_valid,
    input  logic        up_resp_ready,
    output logic [31:0] dn0_req_addr,
    output logic        dn0_req_wen,
    output logic [63:0] dn0_req_wdata,
    output logic [7:0]  dn0_req_wmask,
    output logic [2:0]  dn0_req_size,
    output logic [4:0]  dn0_req_srcid,
    output logic        dn0_req_valid,
    input  logic        dn0_req_ready,
    input  logic [63:0] dn0_resp_rdata,
    input  logic [2:0]  dn0_resp_size,
    input  logic [4:0]  dn0_resp_dstid,
    input  logic        dn0_resp_valid,
    output logic        dn0_resp_ready,
    output logic [31:0] dn1_req_addr,
    output logic        dn1_req_wen,
    output logic [63:0] dn1_req_wdata,
    output logic [7:0]  dn1_req_wmask,
    output logic [2:0]  dn1_req_size,
    output logic [4:0]  dn1_req_srcid,
    output logic        dn1_req_valid,
    input  logic        dn1_req_ready,
    input  logic [63:0] dn1_resp_rdata,
    input  logic [2:0]  dn1_resp_size,
    input  logic [4:0]  dn1_resp_dstid,
    input  logic        dn1_resp_valid,
    output logic        dn1_resp_ready
);

    logic      dst_s, req_sel_s, req_fire_s, req_start_s;
    logic      req_locked_s, req_sel_locked_s;
    kl_beats_t req_beats_s;

    logic      resp_sel_s, resp_fire_s, resp_start_s;
    logic      resp_locked_s, resp_sel_locked_s;
    kl_beats_t resp_beats_s;
    logic      last_resp_r;

    // ---------------- request path ----------------
    assign dst_s     = ((up_req_addr & DN1_ADDR_MASK) == DN1_ADDR_MATCH);
    assign req_sel_s = req_locked_s ? req_sel_locked_s : dst_s;

    // Payload is broadcast; only the valid qualifies the selected port.
    assign dn0_req_addr  = up_req_addr;
    assign dn0_req_wen   = up_req_wen;
    assign dn0_req_wdata = up_req_wdata;
    assign dn0_req_wmask = up_req_wmask;
    assign dn0_req_size  = up_req_size;
    assign dn0_req_srcid = up_req_srcid;
    assign dn1_req_addr  = up_req_addr;
    assign dn1_req_wen   = up_req_wen;
    assign dn1_req_wdata = up_req_wdata;
    assign dn1_req_wmask = up_req_wmask;
    assign dn1_req_size  = up_req_size;
    assign dn1_req_srcid = up_req_srcid;

    assign dn0_req_valid = ~rst & up_req_valid & (req_sel_s == SEL_DN0);
    assign dn1_req_valid = ~rst & up_req_valid & (req_sel_s == SEL_DN1);
    assign up_req_ready  = ~rst & ((req_sel_s == SEL_DN1) ? dn1_req_ready : dn0_req_ready);

    assign req_fire_s  = up_req_valid & up_req_ready;
    assign req_beats_s = kl_beats(up_req_size);
    assign req_start_s = up_req_wen & (req_beats_s > 5'd1);

    kl_burst_tracker #(
        .CNT_W   (MAX_BURST_WIDTH),
        .SEL_RST (SEL_DN0)
    ) u_req_trk (
        .clk         (clk),
        .rst         (rst),
        .fire        (req_fire_s),
        .start_multi (req_start_s),
        .beats       (req_beats_s),
        .sel_in      (req_sel_s),
        .locked      (req_locked_s),
        .sel_locked  (req_sel_locked_s)
    );

    // ---------------- response path ----------------
    // Response grant: burst lock first, then sole requester, then alternate.
    always_comb begin
        resp_sel_s = SEL_DN0;
        if (resp_locked_s) begin
            resp_sel_s = resp_sel_locked_s;
        end else if (dn0_resp_valid && dn1_resp_valid) begin
            resp_sel_s = ~last_resp_r;
        end else if (dn1_resp_valid) begin
            resp_sel_s = SEL_DN1;
        end else begin
            resp_sel_s = SEL_DN0;
        end
    end

    assign up_resp_valid  = ~rst & ((resp_sel_s == SEL_DN1) ? dn1_resp_valid : dn0_resp_valid);
    assign up_resp_rdata  = (resp_sel_s == SEL_DN1) ? dn1_resp_rdata : dn0_resp_rdata;
    assign up_resp_size   = (resp_sel_s == SEL_DN1) ? dn1_resp_size  : dn0_resp_size;
    assign up_resp_dstid  = (resp_sel_s == SEL_DN1) ? dn1_resp_dstid : dn0_resp_dstid;
    assign dn0_resp_ready = ~rst & up_resp_ready & (resp_sel_s == SEL_DN0);
    assign dn1_resp_ready = ~rst & up_resp_ready & (resp_sel_s == SEL_DN1);

    assign resp_fire_s  = up_resp_valid & up_resp_ready;
    assign resp_beats_s = kl_beats(up_resp_size);
    assign resp_start_s = (resp_beats_s > 5'd1);

    // Last-served port, updated only when a new response transfer starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_resp_r <= SEL_DN1;
        end else if (resp_fire_s && !resp_locked_s) begin
            last_resp_r <= resp_sel_s;
        end else begin
            last_resp_r <= last_resp_r;
        end
    end

    kl_burst_tracker #(
        .CNT_W   (MAX_BURST_WIDTH),
        .SEL_RST (SEL_DN1)
    ) u_resp_trk (
        .clk         (clk),
        .rst         (rst),
        .fire        (resp_fire_s),
        .start_multi (resp_start_s),
        .beats       (resp_beats_s),
        .sel_in      (resp_sel_s),
        .locked      (resp_locked_s),
        .sel_locked  (resp_sel_locked_s)
    );

endmodule

// File: tb/tb_kl_router_1by2.sv
// Directed bench for kl_router_1by2: a cycle table of inputs and expected
// routing/handshake outputs, plus a hand-driven locked response burst.
module tb_kl_router_1by2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] up_req_addr;
    logic        up_req_wen;
    logic [63:0] up_req_wdata;
    logic [7:0]  up_req_wmask;
    logic [2:0]  up_req_size;
    logic [4:0]  up_req_srcid;
    logic        up_req_valid, up_req_ready;
    logic [63:0] up_resp_rdata;
    logic [2:0]  up_resp_size;
    logic [4:0]  up_resp_dstid;
    logic        up_resp_valid, up_resp_ready;
    logic [31:0] dn0_req_addr, dn1_req_addr;
    logic        dn0_req_wen, dn1_req_wen;
    logic [63:0] dn0_req_wdata, dn1_req_wdata;
    logic [7:0]  dn0_req_wmask, dn1_req_wmask;
    logic [2:0]  dn0_req_size, dn1_req_size;
    logic [4:0]  dn0_req_srcid, dn1_req_srcid;
    logic        dn0_req_valid, dn0_req_ready, dn1_req_valid, dn1_req_ready;
    logic [63:0] dn0_resp_rdata, dn1_resp_rdata;
    logic [2:0]  dn0_resp_size, dn1_resp_size;
    logic [4:0]  dn0_resp_dstid, dn1_resp_dstid;
    logic        dn0_resp_valid, dn0_resp_ready, dn1_resp_valid, dn1_resp_ready;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    kl_router_1by2 dut (
        .clk(clk), .rst(rst),
        .up_req_addr(up_req_addr), .up_req_wen(up_req_wen), .up_req_wdata(up_req_wdata),
        .up_req_wmask(up_req_wmask), .up_req_size(up_req_size), .up_req_srcid(up_req_srcid),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_resp_rdata(up_resp_rdata), .up_resp_size(up_resp_size), .up_resp_dstid(up_resp_dstid),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
        .dn0_req_addr(dn0_req_addr), .dn0_req_wen(dn0_req_wen), .dn0_req_wdata(dn0_req_wdata),
        .dn0_req_wmask(dn0_req_wmask), .dn0_req_size(dn0_req_size), .dn0_req_srcid(dn0_req_srcid),
        .dn0_req_valid(dn0_req_valid), .dn0_req_ready(dn0_req_ready),
        .dn0_resp_rdata(dn0_resp_rdata), .dn0_resp_size(dn0_resp_size), .dn0_resp_dstid(dn0_resp_dstid),
        .dn0_resp_valid(dn0_resp_valid), .dn0_resp_ready(dn0_resp_ready),
        .dn1_req_addr(dn1_req_addr), .dn1_req_wen(dn1_req_wen), .dn1_req_wdata(dn1_req_wdata),
        .dn1_req_wmask(dn1_req_wmask), .dn1_req_size(dn1_req_size), .dn1_req_srcid(dn1_req_srcid),
        .dn1_req_valid(dn1_req_valid), .dn1_req_ready(dn1_req_ready),
        .dn1_resp_rdata(dn1_resp_rdata), .dn1_resp_size(dn1_resp_size), .dn1_resp_dstid(dn1_resp_dstid),
        .dn1_resp_valid(dn1_resp_valid), .dn1_resp_ready(dn1_resp_ready)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        rv;
        logic [31:0] addr;
        logic        wen;
        logic [2:0]  size;
        logic        r0, r1;
        logic        v0;
        logic [2:0]  s0;
        logic [63:0] d0;
        logic [4:0]  id0;
        logic        v1;
        logic [2:0]  s1;
        logic [63:0] d1;
        logic [4:0]  id1;
        logic        urr;
        logic [2:0]  e_req;   // {dn0_req_valid, dn1_req_valid, up_req_ready}
        logic [2:0]  e_resp;  // {up_resp_valid, dn0_resp_ready, dn1_resp_ready}
        logic [63:0] e_rdata;
        logic [4:0]  e_dstid;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Request-side vector; response side idle (dn0 granted by default, ready passes through).
    task automatic rq(input string nm, input logic r, input logic rv, input logic [31:0] a,
                      input logic w, input logic [2:0] sz, input logic r0, input logic r1,
                      input logic [2:0] e);
        vec_t t;
        t.name = nm; t.rst = r; t.rv = rv; t.addr = a; t.wen = w; t.size = sz;
        t.r0 = r0; t.r1 = r1;
        t.v0 = 1'b0; t.s0 = 3'd0; t.d0 = 64'd0; t.id0 = 5'd0;
        t.v1 = 1'b0; t.s1 = 3'd0; t.d1 = 64'd0; t.id1 = 5'd0;
        t.urr = 1'b1; t.e_req = e; t.e_resp = r ? 3'b000 : 3'b010;
        t.e_rdata = 64'd0; t.e_dstid = 5'd0;
        vq.push_back(t);
    endtask

    // Response-side vector; request side idle at address 0 with both readies high.
    task automatic rs(input string nm, input logic v0, input logic [2:0] s0, input logic [63:0] d0,
                      input logic [4:0] id0, input logic v1, input logic [2:0] s1,
                      input logic [63:0] d1, input logic [4:0] id1, input logic urr,
                      input logic [2:0] e, input logic [63:0] ed, input logic [4:0] eid);
        vec_t t;
        t.name = nm; t.rst = 1'b0; t.rv = 1'b0; t.addr = 32'd0; t.wen = 1'b0; t.size = 3'd0;
        t.r0 = 1'b1; t.r1 = 1'b1;
        t.v0 = v0; t.s0 = s0; t.d0 = d0; t.id0 = id0;
        t.v1 = v1; t.s1 = s1; t.d1 = d1; t.id1 = id1;
        t.urr = urr; t.e_req = 3'b001; t.e_resp = e; t.e_rdata = ed; t.e_dstid = eid;
        vq.push_back(t);
    endtask

    task automatic set_resp(input logic v0, input logic [63:0] d0, input logic v1,
                            input logic [63:0] d1, input logic urr);
        dn0_resp_valid = v0; dn0_resp_size = 3'd3; dn0_resp_rdata = d0; dn0_resp_dstid = 5'd7;
        dn1_resp_valid = v1; dn1_resp_size = 3'd6; dn1_resp_rdata = d1; dn1_resp_dstid = 5'd9;
        up_resp_ready = urr;
    endtask

    task automatic chk_resp(input string nm, input logic [2:0] e, input logic [63:0] ed);
        chk({nm, "_hs"}, {up_resp_valid, dn0_resp_ready, dn1_resp_ready}, e);
        chk({nm, "_data"}, up_resp_rdata, ed);
    endtask

    initial begin
        rst = 1'b1; up_req_valid = 1'b0; up_req_addr = 32'd0; up_req_wen = 1'b0;
        up_req_wdata = 64'h1111_2222_3333_4444; up_req_wmask = 8'hFF; up_req_size = 3'd3;
        up_req_srcid = 5'd1; dn0_req_ready = 1'b1; dn1_req_ready = 1'b1;
        set_resp(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        //   name          rst   rv    addr            wen   sz    r0    r1    {v0,v1,rdy}
        rq("rst0",         1'b1, 1'b1, 32'h0000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b000);
        rq("rst1",         1'b1, 1'b1, 32'h8000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b000);
        rq("rd_dn0",       1'b0, 1'b1, 32'h0000_1000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b101);
        rq("rd_dn1_wait",  1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'd3, 1'b1, 1'b0, 3'b010);
        rq("rd_dn1",       1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b011);
        rq("mask_hi_dn1",  1'b0, 1'b1, 32'h8FFF_FFFC, 1'b0, 3'd3, 1'b1, 1'b1, 3'b011);
        rq("mask_90_dn0",  1'b0, 1'b1, 32'h9000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b101);
        rq("mask_7f_dn0",  1'b0, 1'b1, 32'h7FFF_FFF8, 1'b0, 3'd3, 1'b1, 1'b1, 3'b101);
        rq("idle_rdy",     1'b0, 1'b0, 32'h8000_0000, 1'b0, 3'd3, 1'b0, 1'b1, 3'b001);
        rq("wr8_b1",       1'b0, 1'b1, 32'h8000_0040, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b2",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b3",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b4_stall", 1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b0, 3'b010);
        rq("wr8_b4",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b5",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b6",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b7",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr8_b8",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("wr_after",     1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd3, 1'b1, 1'b1, 3'b101);
        rq("wr2_b1",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd4, 1'b1, 1'b1, 3'b101);
        rq("wr2_b2",       1'b0, 1'b1, 32'h8000_0000, 1'b1, 3'd4, 1'b1, 1'b1, 3'b101);
        rq("rd_after_wr2", 1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("rd_multi_nl",  1'b0, 1'b1, 32'h0000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b101);
        rq("rwr_b1",       1'b0, 1'b1, 32'h8000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("rwr_b2",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("rwr_b3",       1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b011);
        rq("rwr_b4_rst",   1'b1, 1'b1, 32'h0000_0000, 1'b1, 3'd6, 1'b1, 1'b1, 3'b000);
        rq("post_rst_dn1", 1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b011);
        rq("post_rst_dn0", 1'b0, 1'b1, 32'h0000_0000, 1'b0, 3'd3, 1'b1, 1'b1, 3'b101);

        //   name         v0    s0    d0       id0   v1    s1    d1       id1   urr   exp     rdata    dstid
        rs("alt_dn0",     1'b1, 3'd3, 64'hA0, 5'd1, 1'b1, 3'd3, 64'hB0, 5'd2, 1'b1, 3'b110, 64'hA0, 5'd1);
        rs("alt_dn1",     1'b1, 3'd3, 64'hA0, 5'd1, 1'b1, 3'd3, 64'hB0, 5'd2, 1'b1, 3'b101, 64'hB0, 5'd2);
        rs("alt_dn0_b",   1'b1, 3'd3, 64'hA1, 5'd1, 1'b1, 3'd3, 64'hB1, 5'd2, 1'b1, 3'b110, 64'hA1, 5'd1);
        rs("alt_dn1_b",   1'b1, 3'd3, 64'hA1, 5'd1, 1'b1, 3'd3, 64'hB1, 5'd2, 1'b1, 3'b101, 64'hB1, 5'd2);
        rs("dn0_id5",     1'b1, 3'd3, 64'hC5, 5'd5, 1'b0, 3'd3, 64'hB2, 5'd2, 1'b1, 3'b110, 64'hC5, 5'd5);
        rs("hold_nordy",  1'b1, 3'd3, 64'hA2, 5'd1, 1'b1, 3'd3, 64'hB2, 5'd2, 1'b0, 3'b100, 64'hB2, 5'd2);
        rs("hold_rdy",    1'b1, 3'd3, 64'hA2, 5'd1, 1'b1, 3'd3, 64'hB2, 5'd2, 1'b1, 3'b101, 64'hB2, 5'd2);
        rs("none_valid",  1'b0, 3'd3, 64'hA3, 5'd1, 1'b0, 3'd3, 64'hB3, 5'd2, 1'b1, 3'b010, 64'hA3, 5'd1);
        rs("r2_b1",       1'b1, 3'd4, 64'hE1, 5'd3, 1'b1, 3'd3, 64'hB4, 5'd2, 1'b1, 3'b110, 64'hE1, 5'd3);
        rs("r2_b2_lock",  1'b1, 3'd4, 64'hE2, 5'd3, 1'b1, 3'd3, 64'hB4, 5'd2, 1'b1, 3'b110, 64'hE2, 5'd3);
        rs("r2_then_dn1", 1'b1, 3'd3, 64'hA5, 5'd1, 1'b1, 3'd3, 64'hB4, 5'd2, 1'b1, 3'b101, 64'hB4, 5'd2);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; up_req_valid = vq[i].rv; up_req_addr = vq[i].addr;
            up_req_wen = vq[i].wen; up_req_size = vq[i].size;
            dn0_req_ready = vq[i].r0; dn1_req_ready = vq[i].r1;
            dn0_resp_valid = vq[i].v0; dn0_resp_size = vq[i].s0;
            dn0_resp_rdata = vq[i].d0; dn0_resp_dstid = vq[i].id0;
            dn1_resp_valid = vq[i].v1; dn1_resp_size = vq[i].s1;
            dn1_resp_rdata = vq[i].d1; dn1_resp_dstid = vq[i].id1;
            up_resp_ready = vq[i].urr;
            #1;
            chk({vq[i].name, "_req"}, {dn0_req_valid, dn1_req_valid, up_req_ready}, vq[i].e_req);
            chk({vq[i].name, "_resp"}, {up_resp_valid, dn0_resp_ready, dn1_resp_ready}, vq[i].e_resp);
            if (vq[i].e_resp[2]) begin
                chk({vq[i].name, "_rdata"}, {up_resp_rdata, 3'b000, up_resp_dstid},
                    {vq[i].e_rdata, 3'b000, vq[i].e_dstid});
            end
        end

        // dn1 8-beat response; dn0 arrives at beat 3; 5-cycle upstream stall before beat 5.
        up_req_valid = 1'b0; dn0_req_ready = 1'b1; dn1_req_ready = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            if (b == 5) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    set_resp(1'b1, 64'h0F0F, 1'b1, 64'h1100 + 64'(b), 1'b0);
                    #1;
                    chk_resp("burst_stall", 3'b100, 64'h1100 + 64'(b));
                end
            end
            @(negedge clk);
            set_resp(b >= 3, 64'h0F0F, 1'b1, 64'h1100 + 64'(b), 1'b1);
            if (b == 2) begin
                up_req_valid = 1'b1; up_req_addr = 32'h8000_0010; up_req_wen = 1'b1;
                up_req_wdata = 64'h0123_4567_89AB_CDEF; up_req_wmask = 8'h5A;
                up_req_size = 3'd3; up_req_srcid = 5'h13;
            end else begin
                up_req_valid = 1'b0;
            end
            #1;
            chk_resp("burst_beat", 3'b101, 64'h1100 + 64'(b));
            if (b == 8) begin
                chk("burst_size", {5'd0, up_resp_size, 3'd0, up_resp_dstid}, {5'd0, 3'd6, 3'd0, 5'd9});
            end
            if (b == 2) begin
                chk("conc_req_hs", {dn0_req_valid, dn1_req_valid, up_req_ready}, 3'b011);
                chk("conc_req_payload",
                    {dn1_req_addr, dn1_req_wen, dn1_req_wdata, dn1_req_wmask, dn1_req_size, dn1_req_srcid},
                    {32'h8000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h5A, 3'd3, 5'h13});
            end
        end
        @(negedge clk);
        set_resp(1'b1, 64'h0F0F, 1'b0, 64'h0, 1'b1);
        up_req_valid = 1'b0;
        #1;
        chk_resp("dn0_after_burst", 3'b110, 64'h0F0F);

        @(negedge clk);
        set_resp(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
